// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-side driver for the 32x32 integer register file. Two result sources
//   share the file's single write port (we/rd/wd). ALU results take priority.
//   Memory responses are buffered in a small in-order FIFO. A per-register
//   busy scoreboard marks registers that still have a memory write pending.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   alu_valid/rd/wd        single-cycle ALU result, always accepted
//   mem_valid/rd/wd        memory response; accepted when mem_ready is high
//   mem_ready              combinational: FIFO not full and not in reset
//   issue_valid/rd         long-latency op issued; marks issue_rd busy
//   we, rd, wd             registered register-file write port
//   busy                   registered scoreboard, bit n = xn awaits memory data
//   fifo_count             registered number of buffered responses

module regfile_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_wd,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_wd,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    output logic                     we,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          wd,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wb_entry_t;

    // Response storage: data only, no reset needed (validity lives in count_q)
    wb_entry_t        fifo_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             we_q,     we_d;
    logic [4:0]       rd_q,     rd_d;
    logic [XLEN-1:0]  wd_q,     wd_d;
    logic [31:0]      busy_q,   busy_d;

    logic             full_c;
    logic             empty_c;
    logic             alu_wr_c;
    logic             push_c;
    logic             pop_c;
    wb_entry_t        head_c;

    // Flow control: full/empty come from the count, never from the pointers
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == CNT_W'(0));
        alu_wr_c = alu_valid && (alu_rd != 5'd0);
        // No pass-through: a full FIFO refuses even if it pops this cycle
        push_c   = mem_valid && rst_n && !full_c;
        // ALU owns the port whenever it actually writes; x0 writes yield it
        pop_c    = !alu_wr_c && !empty_c;
        head_c   = fifo_q[rd_ptr_q];
    end

    assign mem_ready = rst_n && !full_c;

    // Write-port selection and scoreboard update
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        wd_d   = wd_q;
        busy_d = busy_q;

        if (alu_wr_c) begin
            we_d = 1'b1;
            rd_d = alu_rd;
            wd_d = alu_wd;
        end else if (pop_c && (head_c.rd != 5'd0)) begin
            we_d           = 1'b1;
            rd_d           = head_c.rd;
            wd_d           = head_c.wd;
            busy_d[head_c.rd] = 1'b0;
        end

        // Applied after the clear so a newly issued op keeps its bit
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO data array
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= wb_entry_t'{rd: mem_rd, wd: mem_wd};
        end
    end

    assign we         = we_q;
    assign rd         = rd_q;
    assign wd         = wd_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule
